score_combo_tracker: RTL and testbench
======================================

// Module: score_combo_tracker
// PURPOSE
//   Game-score and combo engine between note-hit detection and the 7-segment score display.
//   Consumes one-cycle hit/miss events, keeps a combo count, a streak multiplier and a
//   saturating score. A multi-cycle double-dabble converter produces four BCD digits for the HEX driver.
// PARAMETERS
//   SCORE_MAX    9999  saturation ceiling for score (four decimal digits)
//   BASE_POINTS  10    points per hit at multiplier 1
//   COMBO_STEP   10    consecutive hits per multiplier increment
//   MULT_MAX     4     multiplier ceiling (1..MULT_MAX)
// PORTS
//   clk         in   1   game clock (25 MHz pixel-clock domain)
//   rst_n       in   1   asynchronous active-low reset
//   clear       in   1   synchronous game restart, level-sampled each cycle
//   hit         in   1   one-cycle pulse: note struck in window
//   miss        in   1   one-cycle pulse: note passed or wrong key
//   score       out  16  binary score, 0..SCORE_MAX
//   combo       out  10  current consecutive-hit count
//   best_combo  out  10  highest combo since reset/clear
//   mult        out  3   current multiplier, 1..MULT_MAX
//   bcd         out  16  {thousands,hundreds,tens,ones} of last converted score
//   bcd_valid   out  1   1 when bcd matches score
// BEHAVIOUR
//   Reset (rst_n=0, async): score=0, combo=0, best_combo=0, mult=1, step counter=0,
//     bcd=0, bcd_valid=1, converter IDLE, pending=0.
//   clear=1 forces the reset values on the next edge, aborts any conversion and ignores
//     hit/miss in that cycle.
//   Registered event path; all counters update on the edge after the pulse (latency 1):
//   hit only:
//     - score += BASE_POINTS*mult (mult as registered before this edge); saturate at SCORE_MAX.
//     - combo += 1, saturating at 1023.
//     - step counter += 1. At COMBO_STEP-1 it wraps to 0 and mult increments, capped at
//       MULT_MAX. Once at MULT_MAX, the counter keeps wrapping with no effect.
//     - best_combo = max(best_combo, new combo).
//   miss only: combo=0, step=0, mult=1; score unchanged.
//   hit and miss in the same cycle: award the hit points at the current mult, then combo=0,
//     step=0, mult=1; best_combo still compares against combo+1.
//   Score arithmetic: 16-bit sum compared to SCORE_MAX. No wrap-around under any input sequence.
//   BCD converter FSM: IDLE -> SHIFT (16 iterations) -> DONE -> IDLE.
//     - Start: any edge where score changes value starts a conversion of the new score
//       (snapshot) on the following cycle.
//     - While running: bcd_valid=0 and bcd holds its previous value.
//     - SHIFT: one shift per cycle, add-3 on any nibble >=5 before each shift.
//     - DONE: loads bcd. bcd_valid=1 in that same cycle unless pending=1.
//     - Timing: bcd_valid returns 18 cycles after the score update edge.
//     - Score change during SHIFT/DONE: sets pending. At DONE with pending=1, the converter
//       reloads the latest score and re-enters SHIFT, and bcd_valid stays 0.
//     - A score that saturates (no change) starts no conversion.
//   hit/miss pulses held high for several cycles count once per cycle; debouncing is upstream.
// TESTING
//   reset, then 3 hits on separate cycles -> score=30, combo=3, mult=1; bcd=0x0030 with
//     bcd_valid=1 18 cycles after the 3rd hit.
//   10 consecutive hits -> mult=2 after the 10th; 11th hit adds 20 -> score=120.
//   40 hits -> mult=4 (capped); 41st-50th hits add 40 each; a miss -> combo=0, mult=1,
//     best_combo=50, score unchanged.
//   score=9990, mult=2, one hit -> score=9999 (saturated); next hit -> score stays 9999,
//     no new conversion, bcd=0x9999.
//   hit and miss in the same cycle at mult=3 -> +30 points, combo=0, mult=1.
//   two hits 5 cycles apart -> pending path; bcd_valid held low until the second
//     conversion ends; bcd equals the final score.
//   Assert clear and rst_n mid-conversion -> all outputs reach reset values; rst_n acts
//     without a clock edge.

Source files
------------

// File: rtl/score_combo_tracker.sv
// Score / combo / multiplier engine with a multi-cycle binary-to-BCD converter
// feeding the four-digit HEX score display.
module score_combo_tracker #(
  parameter int unsigned SCORE_MAX   = 9999,
  parameter int unsigned BASE_POINTS = 10,
  parameter int unsigned COMBO_STEP  = 10,
  parameter int unsigned MULT_MAX    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        hit,
  input  logic        miss,
  output logic [15:0] score,
  output logic [9:0]  combo,
  output logic [9:0]  best_combo,
  output logic [2:0]  mult,
  output logic [15:0] bcd,
  output logic        bcd_valid
);

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned COMBO_W = 10;
  localparam int unsigned MULT_W  = 3;
  localparam int unsigned STEP_W  = $clog2(COMBO_STEP);
  localparam int unsigned BCD_W   = 16;
  localparam int unsigned DD_W    = BCD_W + SCORE_W;
  localparam int unsigned CNT_W   = $clog2(SCORE_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } conv_state_t;

  // Event path state and next values
  logic [STEP_W-1:0]  step;
  logic [SCORE_W-1:0] score_nxt;
  logic [COMBO_W-1:0] combo_nxt;
  logic [COMBO_W-1:0] best_nxt;
  logic [MULT_W-1:0]  mult_nxt;
  logic [STEP_W-1:0]  step_nxt;
  logic [SCORE_W-1:0] points_c;
  logic [SCORE_W:0]   sum_c;
  logic [COMBO_W-1:0] combo_inc_c;
  logic               score_upd_c;

  // Converter state and next values
  conv_state_t        state, state_nxt;
  logic [DD_W-1:0]    shreg, shreg_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               pending, pending_nxt;
  logic [BCD_W-1:0]   bcd_nxt;
  logic               bcd_valid_nxt;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[SCORE_W+4*i +: 4] >= 4'd5) r[SCORE_W+4*i +: 4] = r[SCORE_W+4*i +: 4] + 4'd3;
    end
    return {r[DD_W-2:0], 1'b0};
  endfunction

  // Hit/miss scoring: points at the pre-edge multiplier, saturating score and combo.
  always_comb begin
    score_nxt   = score;
    combo_nxt   = combo;
    best_nxt    = best_combo;
    mult_nxt    = mult;
    step_nxt    = step;
    points_c    = SCORE_W'(BASE_POINTS) * SCORE_W'(mult);
    sum_c       = {1'b0, score} + {1'b0, points_c};
    combo_inc_c = (combo == '1) ? combo : combo + COMBO_W'(1);
    if (hit) begin
      score_nxt = (sum_c > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum_c[SCORE_W-1:0];
      combo_nxt = combo_inc_c;
      if (combo_inc_c > best_combo) best_nxt = combo_inc_c;
      if (step == STEP_W'(COMBO_STEP - 1)) begin
        step_nxt = '0;
        if (mult != MULT_W'(MULT_MAX)) mult_nxt = mult + MULT_W'(1);
      end else begin
        step_nxt = step + STEP_W'(1);
      end
    end
    if (miss) begin
      combo_nxt = '0;
      step_nxt  = '0;
      mult_nxt  = MULT_W'(1);
    end
    score_upd_c = (score_nxt != score);
  end

  // Event path registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score      <= '0;
      combo      <= '0;
      best_combo <= '0;
      mult       <= MULT_W'(1);
      step       <= '0;
    end else if (clear) begin
      score      <= '0;
      combo      <= '0;
      best_combo <= '0;
      mult       <= MULT_W'(1);
      step       <= '0;
    end else begin
      score      <= score_nxt;
      combo      <= combo_nxt;
      best_combo <= best_nxt;
      mult       <= mult_nxt;
      step       <= step_nxt;
    end
  end

  // Converter next state: snapshot score, 16 shifts, then publish or restart if stale.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    cnt_nxt       = cnt;
    pending_nxt   = pending;
    bcd_nxt       = bcd;
    bcd_valid_nxt = bcd_valid;
    case (state)
      S_IDLE: begin
        if (pending) begin
          shreg_nxt   = {BCD_W'(0), score};
          cnt_nxt     = '0;
          pending_nxt = 1'b0;
          state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_nxt = dd_step(shreg);
        cnt_nxt   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SCORE_W - 1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (pending) begin
          shreg_nxt   = {BCD_W'(0), score};
          cnt_nxt     = '0;
          pending_nxt = 1'b0;
          state_nxt   = S_SHIFT;
        end else begin
          bcd_nxt       = shreg[DD_W-1:SCORE_W];
          bcd_valid_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A score change always invalidates the display and queues a conversion.
    if (score_upd_c) begin
      pending_nxt   = 1'b1;
      bcd_valid_nxt = 1'b0;
    end
  end

  // Converter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
    end else if (clear) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      pending   <= pending_nxt;
      bcd       <= bcd_nxt;
      bcd_valid <= bcd_valid_nxt;
    end
  end

endmodule

// File: tb/tb_score_combo_tracker.sv
// Bench for score_combo_tracker: scoring/timing model compared every cycle,
// plus hand-computed checkpoints.
module tb_score_combo_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear, hit, miss;
  logic [15:0] score;
  logic [9:0]  combo, best_combo;
  logic [2:0]  mult;
  logic [15:0] bcd;
  logic        bcd_valid;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  score_combo_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .hit        (hit),
    .miss       (miss),
    .score      (score),
    .combo      (combo),
    .best_combo (best_combo),
    .mult       (mult),
    .bcd        (bcd),
    .bcd_valid  (bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_score, m_streak, m_best, m_edge;
  logic [15:0] m_bcd;
  bit          m_valid, m_busy, m_pend;
  int          m_snap_edge, m_snap_val;
  int          old_s, new_s, nc;
  bit          upd;

  function automatic int mult_of(input int s);
    return (1 + s / 10 > 4) ? 4 : 1 + s / 10;
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic m_reset();
    m_score  = 0;
    m_streak = 0;
    m_best   = 0;
    m_bcd    = 16'h0;
    m_valid  = 1'b1;
    m_busy   = 1'b0;
    m_pend   = 1'b0;
  endtask

  // Model update on each clock edge; a conversion finishes 17 edges after its snapshot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      m_edge++;
      if (clear) begin
        m_reset();
      end else begin
        old_s = m_score;
        new_s = old_s;
        if (hit) begin
          new_s = old_s + 10 * mult_of(m_streak);
          if (new_s > 9999) new_s = 9999;
          nc = (m_streak + 1 > 1023) ? 1023 : m_streak + 1;
          if (nc > m_best) m_best = nc;
        end
        if (miss) m_streak = 0;
        else if (hit) m_streak++;
        m_score = new_s;
        upd = (new_s != old_s);
        if (!m_busy) begin
          if (m_pend) begin
            m_busy      = 1'b1;
            m_snap_edge = m_edge;
            m_snap_val  = old_s;
          end
          m_pend = upd;
        end else if (m_edge == m_snap_edge + 17) begin
          if (m_pend) begin
            m_snap_edge = m_edge;
            m_snap_val  = old_s;
          end else begin
            m_busy  = 1'b0;
            m_bcd   = bcd_of(m_snap_val);
            m_valid = 1'b1;
          end
          m_pend = upd;
        end else begin
          m_pend = m_pend | upd;
        end
        if (upd) m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("score", 32'(score), 32'(m_score));
      chk("combo", 32'(combo), 32'((m_streak > 1023) ? 1023 : m_streak));
      chk("best_combo", 32'(best_combo), 32'(m_best));
      chk("mult", 32'(mult), 32'(mult_of(m_streak)));
      chk("bcd", 32'(bcd), 32'(m_bcd));
      chk("bcd_valid", 32'(bcd_valid), 32'(m_valid));
    end
  end

  task automatic tick(input logic h, input logic m, input logic c);
    @(negedge clk);
    hit   = h;
    miss  = m;
    clear = c;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    hit = 1'b0; miss = 1'b0; clear = 1'b0;
    m_edge = 0;
    m_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick(0, 0, 0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_mult", 32'(mult), 32'd1);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_valid", 32'(bcd_valid), 32'd1);

    // Three well-spaced hits; display settles 18 cycles after the last one
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0);
      repeat (20) tick(0, 0, 0);
    end
    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("h3_score", 32'(score), 32'd30);
    chk("h3_combo", 32'(combo), 32'd3);
    chk("h3_mult", 32'(mult), 32'd1);
    repeat (17) tick(0, 0, 0);
    chk("h3_valid_17", 32'(bcd_valid), 32'd0);
    tick(0, 0, 0);
    chk("h3_valid_18", 32'(bcd_valid), 32'd1);
    chk("h3_bcd", 32'(bcd), 32'h0030);

    // Clear, then multiplier step after ten hits
    tick(0, 0, 1);
    tick(0, 0, 0);
    chk("clr_score", 32'(score), 32'd0);
    chk("clr_best", 32'(best_combo), 32'd0);
    repeat (10) tick(1, 0, 0);
    tick(0, 0, 0);
    chk("h10_mult", 32'(mult), 32'd2);
    chk("h10_score", 32'(score), 32'd100);
    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("h11_score", 32'(score), 32'd120);

    // Multiplier cap and miss
    tick(0, 0, 1);
    repeat (40) tick(1, 0, 0);
    tick(0, 0, 0);
    chk("h40_mult", 32'(mult), 32'd4);
    chk("h40_score", 32'(score), 32'd1000);
    repeat (10) tick(1, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("miss_combo", 32'(combo), 32'd0);
    chk("miss_mult", 32'(mult), 32'd1);
    chk("miss_best", 32'(best_combo), 32'd50);
    chk("miss_score", 32'(score), 32'd1400);

    // Saturation: build score 9990 at mult 2
    tick(0, 0, 1);
    repeat (262) tick(1, 0, 0);
    tick(0, 1, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    repeat (10) tick(1, 0, 0);
    tick(0, 0, 0);
    chk("pre_sat_score", 32'(score), 32'd9990);
    chk("pre_sat_mult", 32'(mult), 32'd2);
    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("sat_score", 32'(score), 32'd9999);
    repeat (40) tick(0, 0, 0);
    chk("sat_bcd", 32'(bcd), 32'h9999);
    chk("sat_valid", 32'(bcd_valid), 32'd1);
    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("sat2_score", 32'(score), 32'd9999);
    chk("sat2_valid", 32'(bcd_valid), 32'd1);

    // Simultaneous hit and miss at mult 3
    tick(0, 0, 1);
    repeat (20) tick(1, 0, 0);
    tick(0, 0, 0);
    chk("hm_pre_mult", 32'(mult), 32'd3);
    tick(1, 1, 0);
    tick(0, 0, 0);
    chk("hm_score", 32'(score), 32'd330);
    chk("hm_combo", 32'(combo), 32'd0);
    chk("hm_mult", 32'(mult), 32'd1);
    chk("hm_best", 32'(best_combo), 32'd21);
    repeat (40) tick(0, 0, 0);
    chk("hm_bcd", 32'(bcd), 32'h0330);

    // Pending path: second update lands mid-conversion
    tick(1, 0, 0);
    repeat (4) tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (30) tick(0, 0, 0);
    chk("pend_valid_lo", 32'(bcd_valid), 32'd0);
    chk("pend_bcd_old", 32'(bcd), 32'h0330);
    tick(0, 0, 0);
    chk("pend_valid_hi", 32'(bcd_valid), 32'd1);
    chk("pend_bcd", 32'(bcd), 32'h0350);

    // Clear mid-conversion
    tick(1, 0, 0);
    repeat (5) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    chk("clrmid_score", 32'(score), 32'd0);
    chk("clrmid_bcd", 32'(bcd), 32'h0);
    chk("clrmid_valid", 32'(bcd_valid), 32'd1);
    chk("clrmid_best", 32'(best_combo), 32'd0);
    repeat (20) tick(0, 0, 0);

    // Asynchronous reset mid-conversion, observed between clock edges
    tick(1, 0, 0);
    repeat (3) tick(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_best", 32'(best_combo), 32'd0);
    chk("arst_mult", 32'(mult), 32'd1);
    chk("arst_valid", 32'(bcd_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) tick(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
